// File: rtl/igs027a_mailbox_hle.sv
`default_nettype none
// ============================================================================
//  Module      : igs027a_mailbox_hle
//  Description : 68k-facing HLE of the IGS027A ARM protection mailbox.
//                Commands are queued in a FIFO and executed one at a time
//                after a programmable latency against a small data register
//                file and a shared RAM reached through an auto-increment
//                window. Raises a level completion IRQ.
//  Revision    : 1.0 - initial parametrised release
// ============================================================================
module igs027a_mailbox_hle #(
    parameter int DATA_REGS      = 4,
    parameter int CMD_FIFO_DEPTH = 4,
    parameter int PROC_LATENCY   = 16,
    parameter int RAM_AW         = 8,
    parameter int ADDR_W         = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] addr,
    input  logic [15:0]       din,
    output logic [15:0]       dout,
    input  logic              we,
    input  logic              re,
    output logic              dtack_n,
    output logic              irq
);
    localparam int FIFO_PW   = $clog2(CMD_FIFO_DEPTH);
    localparam int CNT_W     = $clog2(PROC_LATENCY + 1);
    localparam int DI_W      = $clog2(DATA_REGS);
    localparam int RAM_WORDS = 1 << RAM_AW;

    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_LOAD = 3'd1;
    localparam logic [2:0] ST_WAIT = 3'd2;
    localparam logic [2:0] ST_SUM  = 3'd3;
    localparam logic [2:0] ST_DONE = 3'd4;

    // Storage
    logic [15:0]       ram      [RAM_WORDS];
    logic [15:0]       data     [DATA_REGS];
    logic [7:0]        fifo_mem [CMD_FIFO_DEPTH];
    logic [FIFO_PW:0]  wr_ptr;
    logic [FIFO_PW:0]  rd_ptr;

    // Engine state
    logic [2:0]        state;
    logic [7:0]        cmd;
    logic [CNT_W-1:0]  cnt;
    logic [RAM_AW-1:0] sum_addr;
    logic [15:0]       sum_left;
    logic [15:0]       acc;
    logic              busy;
    logic              done;
    logic [7:0]        last_cmd;

    // Host-visible control state
    logic              error;
    logic              irq_en;
    logic [RAM_AW-1:0] ptr;

    // Decode and helpers
    logic              sel_cmd;
    logic              sel_ptr;
    logic              sel_win;
    logic              sel_ctrl;
    logic              sel_data;
    logic [DI_W-1:0]   data_idx;
    logic              fifo_empty;
    logic              fifo_full;
    logic              pop;
    logic              push_req;
    logic              push_ok;
    logic              push_drop;
    logic              in_done;
    logic              cmd_bad;
    logic              ctrl_wr;
    logic [RAM_AW-1:0] op_addr;
    logic [15:0]       status;
    logic [15:0]       rd_val;

    assign sel_cmd    = (addr == ADDR_W'(0));
    assign sel_ptr    = (addr == ADDR_W'(1));
    assign sel_win    = (addr == ADDR_W'(2));
    assign sel_ctrl   = (addr == ADDR_W'(3));
    assign sel_data   = (addr >= ADDR_W'(4)) && (addr < ADDR_W'(4 + DATA_REGS));
    assign data_idx   = DI_W'(addr - ADDR_W'(4));

    assign fifo_empty = (wr_ptr == rd_ptr);
    assign fifo_full  = (wr_ptr[FIFO_PW] != rd_ptr[FIFO_PW]) &&
                        (wr_ptr[FIFO_PW-1:0] == rd_ptr[FIFO_PW-1:0]);
    assign pop        = (state == ST_IDLE) && !fifo_empty;
    // A pop in the same cycle frees a slot, so a push to a full FIFO is
    // only dropped when the engine is not dequeuing.
    assign push_req   = we && sel_cmd;
    assign push_ok    = push_req && (!fifo_full || pop);
    assign push_drop  = push_req && !push_ok;

    assign in_done    = (state == ST_DONE);
    assign cmd_bad    = (cmd < 8'h11) || (cmd > 8'h15);
    assign ctrl_wr    = we && sel_ctrl;
    assign op_addr    = data[0][RAM_AW-1:0];
    assign status     = {last_cmd, 3'b000, error, fifo_empty, fifo_full, busy, done};

    // Host read mux; unmapped addresses (including write-only ctrl) read FFFF
    always_comb begin
        rd_val = 16'hFFFF;
        if (sel_cmd)       rd_val = status;
        else if (sel_ptr)  rd_val = 16'(ptr);
        else if (sel_win)  rd_val = ram[ptr];
        else if (sel_data) rd_val = data[data_idx];
    end

    // Bus handshake: one-cycle acknowledge, read data captured alongside
    always_ff @(posedge clk) begin
        if (reset) begin
            dout    <= 16'hFFFF;
            dtack_n <= 1'b1;
        end else begin
            dtack_n <= !(we || re);
            if (re && !we) dout <= rd_val;
        end
    end

    // Command FIFO pointers
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + (FIFO_PW + 1)'(1);
            if (pop)     rd_ptr <= rd_ptr + (FIFO_PW + 1)'(1);
        end
    end

    // Command FIFO storage; only the decoded low byte is kept
    always_ff @(posedge clk) begin
        if (push_ok) fifo_mem[wr_ptr[FIFO_PW-1:0]] <= din[7:0];
    end

    // Shared RAM: host window writes, engine store command writes last
    always_ff @(posedge clk) begin
        if (we && sel_win)              ram[ptr]     <= din;
        if (in_done && (cmd == 8'h12))  ram[op_addr] <= data[1];
    end

    // RAM window pointer, advances once per window access
    always_ff @(posedge clk) begin
        if (reset) begin
            ptr <= '0;
        end else if (we && sel_ptr) begin
            ptr <= din[RAM_AW-1:0];
        end else if ((we || re) && sel_win) begin
            ptr <= ptr + RAM_AW'(1);
        end
    end

    // Data registers: host writes, engine results override on collision
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DATA_REGS; i++) data[i] <= '0;
        end else begin
            if (we && sel_data) data[data_idx] <= din;
            if (in_done) begin
                case (cmd)
                    8'h11: begin
                        data[0] <= 16'h55AA;
                        data[1] <= 16'hAA55;
                    end
                    8'h13:   data[1] <= ram[op_addr];
                    8'h15:   data[2] <= acc;
                    default: ;
                endcase
            end
        end
    end

    // Command engine: dequeue, wait out the latency, optional sum, complete
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= ST_IDLE;
            cmd      <= '0;
            cnt      <= '0;
            sum_addr <= '0;
            sum_left <= '0;
            acc      <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            last_cmd <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (pop) begin
                        cmd   <= fifo_mem[rd_ptr[FIFO_PW-1:0]];
                        busy  <= 1'b1;
                        done  <= 1'b0;
                        state <= ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    cnt   <= CNT_W'(PROC_LATENCY - 1);
                    state <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (cnt == '0) begin
                        if (cmd == 8'h15) begin
                            // Sum operands are sampled once, on entry
                            sum_addr <= op_addr;
                            sum_left <= data[1];
                            acc      <= '0;
                            state    <= ST_SUM;
                        end else begin
                            state <= ST_DONE;
                        end
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                ST_SUM: begin
                    if (sum_left == '0) begin
                        state <= ST_DONE;
                    end else begin
                        acc      <= acc + ram[sum_addr];
                        sum_addr <= sum_addr + RAM_AW'(1);
                        sum_left <= sum_left - 16'd1;
                    end
                end
                ST_DONE: begin
                    done     <= 1'b1;
                    busy     <= 1'b0;
                    last_cmd <= cmd;
                    state    <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Sticky error: overflow or unknown command sets, ctrl bit2 clears
    always_ff @(posedge clk) begin
        if (reset) begin
            error <= 1'b0;
        end else if (push_drop || (in_done && cmd_bad)) begin
            error <= 1'b1;
        end else if (ctrl_wr && din[2]) begin
            error <= 1'b0;
        end
    end

    // IRQ enable bit
    always_ff @(posedge clk) begin
        if (reset) begin
            irq_en <= 1'b0;
        end else if (ctrl_wr) begin
            irq_en <= din[0];
        end
    end

    // Completion IRQ: a new completion beats a simultaneous ack/disable
    always_ff @(posedge clk) begin
        if (reset) begin
            irq <= 1'b0;
        end else if (in_done && irq_en) begin
            irq <= 1'b1;
        end else if (ctrl_wr && (din[1] || !din[0])) begin
            irq <= 1'b0;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_igs027a_mailbox_hle.sv
`default_nettype none
// ============================================================================
//  Module      : tb_igs027a_mailbox_hle
//  Description : Self-checking bench for igs027a_mailbox_hle with a
//                behavioural model of the shared RAM and data registers.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_igs027a_mailbox_hle;
    localparam int RAM_WORDS = 256;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  addr;
    logic [15:0] din;
    logic [15:0] dout;
    logic        we;
    logic        re;
    logic        dtack_n;
    logic        irq;

    int          vectors     = 0;
    int          miscompares = 0;
    int          comp_cnt    = 0;
    logic        done_q      = 1'b0;

    logic [15:0] model_ram [RAM_WORDS];

    igs027a_mailbox_hle #(
        .DATA_REGS      (4),
        .CMD_FIFO_DEPTH (4),
        .PROC_LATENCY   (16),
        .RAM_AW         (8),
        .ADDR_W         (4)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .addr    (addr),
        .din     (din),
        .dout    (dout),
        .we      (we),
        .re      (re),
        .dtack_n (dtack_n),
        .irq     (irq)
    );

    always #5 clk = ~clk;

    // Count completions as rising edges of the done flag
    always @(posedge clk) begin
        done_q <= dut.done;
        if (dut.done && !done_q) comp_cnt <= comp_cnt + 1;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit exceeded");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
        end
    endtask

    task automatic wr(input logic [3:0] a, input logic [15:0] d);
        @(negedge clk);
        addr = a; din = d; we = 1'b1;
        @(negedge clk);
        we = 1'b0;
    endtask

    task automatic rd(input logic [3:0] a, output logic [15:0] d);
        @(negedge clk);
        addr = a; re = 1'b1;
        @(negedge clk);
        re = 1'b0;
        d = dout;
    endtask

    task automatic wait_idle(output logic [15:0] s, output logic saw_busy);
        int  n;
        logic ok;
        n = 0; ok = 1'b0; saw_busy = 1'b0;
        while (!ok && n < 400) begin
            rd(4'd0, s);
            if (s[1]) saw_busy = 1'b1;
            ok = s[0] && !s[1] && s[3];
            n++;
        end
        vectors++;
        assert (ok) else begin
            miscompares++;
            $error("FAIL idle_timeout: observed status %h after %0d polls, expected idle+done", s, n);
        end
    endtask

    // Reference: wrapping 16-bit sum of n words starting at a, address mod 256
    function automatic logic [15:0] model_sum(input int a, input int n);
        logic [15:0] acc;
        acc = 16'h0000;
        for (int k = 0; k < n; k++) acc = acc + model_ram[(a + k) % RAM_WORDS];
        return acc;
    endfunction

    initial begin
        logic [15:0] s, v, got;
        logic        saw;
        logic [7:0]  a8, hi, c8;
        int          op, len, base;

        reset = 1'b1; addr = '0; din = '0; we = 1'b0; re = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        check("reset_dout", dout, 16'hFFFF);
        check("reset_dtack", {15'd0, dtack_n}, 16'd1);
        check("reset_irq", {15'd0, irq}, 16'd0);

        // Status read with handshake timing
        @(negedge clk); addr = 4'd0; re = 1'b1;
        @(negedge clk); re = 1'b0;
        check("ack_low", {15'd0, dtack_n}, 16'd0);
        check("status_reset", dout, 16'h0008);
        @(negedge clk);
        check("ack_one_cycle", {15'd0, dtack_n}, 16'd1);

        // Command 11
        wr(4'd0, 16'h0011);
        wait_idle(s, saw);
        check("c11_busy_seen", {15'd0, saw}, 16'd1);
        check("c11_status", s, 16'h1109);
        rd(4'd4, got); check("c11_data0", got, 16'h55AA);
        rd(4'd5, got); check("c11_data1", got, 16'hAA55);

        // Fill shared RAM through the window
        wr(4'd1, 16'h0000);
        for (int i = 0; i < RAM_WORDS; i++) begin
            v = 16'($urandom);
            wr(4'd2, v);
            model_ram[i] = v;
        end
        rd(4'd1, got); check("ptr_wrap_fill", got, 16'h0000);

        // Store then load through commands 12/13
        wr(4'd4, 16'h0005); wr(4'd5, 16'h1234); wr(4'd0, 16'h0012);
        wait_idle(s, saw); model_ram[5] = 16'h1234;
        check("c12_status", s, 16'h1209);
        wr(4'd5, 16'h0000); wr(4'd0, 16'h0013);
        wait_idle(s, saw);
        rd(4'd5, got); check("c13_data1", got, model_ram[5]);
        wr(4'd1, 16'h0005);
        rd(4'd2, got); check("win_read", got, model_ram[5]);
        rd(4'd1, got); check("win_ptr_inc", got, 16'h0006);

        // Sum across the RAM wrap
        wr(4'd1, 16'h00FE);
        wr(4'd2, 16'h8000); wr(4'd2, 16'h8000); wr(4'd2, 16'h0001);
        model_ram[254] = 16'h8000; model_ram[255] = 16'h8000; model_ram[0] = 16'h0001;
        rd(4'd1, got); check("win_ptr_wrap", got, 16'h0001);
        wr(4'd4, 16'h00FE); wr(4'd5, 16'h0003); wr(4'd0, 16'h0015);
        wait_idle(s, saw);
        rd(4'd6, got); check("sum_wrap", got, model_sum(254, 3));
        wr(4'd5, 16'h0000); wr(4'd0, 16'h0015);
        wait_idle(s, saw);
        rd(4'd6, got); check("sum_zero", got, 16'h0000);

        // Randomised command mix
        for (int it = 0; it < 16; it++) begin
            op = int'($urandom_range(0, 4));
            a8 = 8'($urandom);
            hi = 8'($urandom);
            case (op)
                0: begin
                    v = 16'($urandom);
                    wr(4'd4, {hi, a8}); wr(4'd5, v); wr(4'd0, {hi, 8'h12});
                    wait_idle(s, saw); model_ram[a8] = v;
                    check("rnd_c12_status", s, 16'h1209);
                    wr(4'd1, {8'h00, a8});
                    rd(4'd2, got); check("rnd_c12_ram", got, model_ram[a8]);
                end
                1: begin
                    wr(4'd4, {hi, a8}); wr(4'd5, 16'($urandom)); wr(4'd0, {hi, 8'h13});
                    wait_idle(s, saw);
                    check("rnd_c13_status", s, 16'h1309);
                    rd(4'd5, got); check("rnd_c13_data1", got, model_ram[a8]);
                end
                2: begin
                    len = int'($urandom_range(0, 24));
                    wr(4'd4, {hi, a8}); wr(4'd5, 16'(len)); wr(4'd0, {hi, 8'h15});
                    wait_idle(s, saw);
                    check("rnd_c15_status", s, 16'h1509);
                    rd(4'd6, got); check("rnd_c15_sum", got, model_sum(int'(a8), len));
                end
                3: begin
                    v = 16'($urandom);
                    wr(4'd7, v); wr(4'd0, {hi, 8'h14});
                    wait_idle(s, saw);
                    check("rnd_c14_status", s, 16'h1409);
                    rd(4'd7, got); check("rnd_c14_data3", got, v);
                end
                default: begin
                    c8 = 8'($urandom);
                    while (c8 >= 8'h11 && c8 <= 8'h15) c8 = 8'($urandom);
                    wr(4'd0, {hi, c8});
                    wait_idle(s, saw);
                    check("rnd_bad_status", s, {c8, 8'h19});
                    wr(4'd3, 16'h0004);
                    rd(4'd0, got); check("rnd_err_clear", got, {c8, 8'h09});
                end
            endcase
        end

        // Back-to-back pushes while the engine is busy: fifth is dropped
        wr(4'd1, 16'h00AA); wr(4'd2, 16'h1357); model_ram[8'hAA] = 16'h1357;
        wr(4'd3, 16'h0001);
        check("irq_before_burst", {15'd0, irq}, 16'd0);
        base = comp_cnt;
        wr(4'd0, 16'h0014);
        we = 1'b1; addr = 4'd0; din = 16'h0011;
        @(negedge clk); din = 16'h0013;
        @(negedge clk); din = 16'h0014;
        @(negedge clk); din = 16'h0014;
        @(negedge clk); din = 16'h0011;
        @(negedge clk); we = 1'b0;
        for (int k = 0; k < 200 && !irq; k++) @(negedge clk);
        @(negedge clk);
        check("irq_first_done", {15'd0, irq}, 16'd1);
        check("first_done_count", 16'(comp_cnt - base), 16'd1);
        wait_idle(s, saw);
        check("burst_status", s, 16'h1419);
        check("burst_completions", 16'(comp_cnt - base), 16'd5);
        rd(4'd4, got); check("burst_data0", got, 16'h55AA);
        rd(4'd5, got); check("burst_data1", got, model_ram[8'hAA]);
        check("irq_held", {15'd0, irq}, 16'd1);
        wr(4'd3, 16'h0003);
        check("irq_ack", {15'd0, irq}, 16'd0);

        // Reset while a command is waiting out its latency
        wr(4'd0, 16'h0011);
        repeat (6) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        base = comp_cnt;
        check("abort_irq", {15'd0, irq}, 16'd0);
        check("abort_dout", dout, 16'hFFFF);
        rd(4'd0, got); check("abort_status", got, 16'h0008);
        rd(4'd4, got); check("abort_data0", got, 16'h0000);
        repeat (60) @(negedge clk);
        rd(4'd0, got); check("abort_status_late", got, 16'h0008);
        rd(4'd4, got); check("abort_data0_late", got, 16'h0000);
        check("abort_no_completion", 16'(comp_cnt - base), 16'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
